// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES256 round-key store.
//   AES256_NUM_RK : number of round keys in an AES256 schedule
//   KEY_W / WORD_W: round-key width and load-stream word width
package aes_key_pkg;
  localparam int AES256_NUM_RK = 15;
  localparam int KEY_W         = 128;
  localparam int WORD_W        = 32;

  typedef logic [KEY_W-1:0] rk_t;

  typedef enum logic {RK_ENC = 1'b0, RK_DEC = 1'b1} rk_mode_t;
  typedef enum logic {RK_LOAD, RK_LOADED} rk_state_t;
endpackage

// File: rtl/rk_word_packer.sv
// Shift-in assembler turning a WORD_WIDTH stream into DATA_WIDTH keys.
// The first word of a key ends up in the MSBs.
//   clk, rst    : clock, async active-high reset
//   clear       : restart at word 0, dropping any partial key
//   word_valid  : a word transfers this cycle
//   word        : the word
//   key_valid   : this word completes a key (combinational)
//   key         : assembled key, meaningful while key_valid
// DATA_WIDTH must hold at least two words.
module rk_word_packer
  import aes_key_pkg::*;
#(
  parameter int DATA_WIDTH = KEY_W,
  parameter int WORD_WIDTH = WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  key_valid,
  output logic [DATA_WIDTH-1:0] key
);
  localparam int WPK   = DATA_WIDTH / WORD_WIDTH;
  localparam int CW    = $clog2(WPK);
  localparam int ACC_W = DATA_WIDTH - WORD_WIDTH;

  logic [CW-1:0]    wcnt;
  logic [ACC_W-1:0] acc;
  logic             last;

  assign last      = (wcnt == CW'(WPK - 1));
  // Earlier words are already in acc; the current word completes the LSBs.
  assign key       = {acc, word};
  assign key_valid = word_valid && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
      acc  <= '0;
    end else if (clear) begin
      wcnt <= '0;
    end else if (word_valid) begin
      acc  <= key[ACC_W-1:0];
      wcnt <= last ? '0 : wcnt + 1'b1;
    end
  end
endmodule

// File: rtl/round_key_store.sv
// Run-time loadable AES256 round-key store feeding the addRK stage.
//   clk, resetn          : clock, async active-high reset
//   clear                : invalidate store, restart load at key 0 word 0
//   ld_valid/ld_data     : load word stream, accepted while ld_ready
//   ld_ready             : high only while loading
//   keys_loaded          : every key written
//   rd_req/rd_mode/rd_round : read request (mode 1 maps round r to key N-1-r)
//   rd_valid/rd_key/rd_err  : registered response one cycle after rd_req
module round_key_store
  import aes_key_pkg::*;
#(
  parameter int DATA_WIDTH = KEY_W,
  parameter int WORD_WIDTH = WORD_W,
  parameter int NUM_KEYS   = AES256_NUM_RK,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  ld_valid,
  input  logic [WORD_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  keys_loaded,
  input  logic                  rd_req,
  input  logic                  rd_mode,
  input  logic [ADDR_WIDTH-1:0] rd_round,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_key,
  output logic                  rd_err
);
  localparam logic [ADDR_WIDTH-1:0] LAST_RK = ADDR_WIDTH'(NUM_KEYS - 1);

  rk_state_t             state;
  logic [ADDR_WIDTH-1:0] key_cnt;
  logic                  xfer;
  logic                  key_valid;
  logic [DATA_WIDTH-1:0] packed_key;
  logic [DATA_WIDTH-1:0] mem [NUM_KEYS];
  logic                  rd_bad;
  logic [ADDR_WIDTH-1:0] phys;

  // clear wins over a same-cycle word: that word is dropped.
  assign xfer = ld_valid && ld_ready && !clear;

  rk_word_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (resetn),
    .clear      (clear),
    .word_valid (xfer),
    .word       (ld_data),
    .key_valid  (key_valid),
    .key        (packed_key)
  );

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state       <= RK_LOAD;
      key_cnt     <= '0;
      ld_ready    <= 1'b1;
      keys_loaded <= 1'b0;
    end else if (clear) begin
      state       <= RK_LOAD;
      key_cnt     <= '0;
      ld_ready    <= 1'b1;
      keys_loaded <= 1'b0;
    end else begin
      case (state)
        RK_LOAD: begin
          if (key_valid) begin
            if (key_cnt == LAST_RK) begin
              state       <= RK_LOADED;
              ld_ready    <= 1'b0;
              keys_loaded <= 1'b1;
            end else begin
              key_cnt <= key_cnt + 1'b1;
            end
          end
        end
        default: ;  // RK_LOADED: load stream is ignored until clear
      endcase
    end
  end

  // Storage is deliberately not reset; stale contents are masked by keys_loaded.
  always_ff @(posedge clk) begin
    if (key_valid) mem[key_cnt] <= packed_key;
  end

  // Range check uses the logical round, before decrypt remapping.
  assign rd_bad = !keys_loaded || (rd_round > LAST_RK);
  assign phys   = (rk_mode_t'(rd_mode) == RK_DEC) ? LAST_RK - rd_round : rd_round;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rd_valid <= 1'b0;
      rd_key   <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_err <= rd_bad;
        rd_key <= rd_bad ? '0 : mem[phys];
      end
    end
  end
endmodule

// File: tb/tb_round_key_store.sv
// Self-checking bench for round_key_store: read responses are scored
// against a queue of expected results filled when requests are issued.
module tb_round_key_store;
  import aes_key_pkg::*;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         clear = 1'b0;
  logic         ld_valid = 1'b0;
  logic [31:0]  ld_data = '0;
  logic         ld_ready, keys_loaded;
  logic         rd_req = 1'b0, rd_mode = 1'b0;
  logic [3:0]   rd_round = '0;
  logic         rd_valid;
  logic [127:0] rd_key;
  logic         rd_err;

  round_key_store dut (
    .clk(clk), .resetn(resetn), .clear(clear),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .keys_loaded(keys_loaded), .rd_req(rd_req), .rd_mode(rd_mode),
    .rd_round(rd_round), .rd_valid(rd_valid), .rd_key(rd_key), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         err;
    logic [127:0] key;
  } resp_t;

  resp_t        q[$];
  int           n_vec = 0, n_err = 0;
  logic [127:0] model_key [15];
  bit           model_loaded = 0;

  function automatic resp_t exp_of(input logic mode, input int round);
    resp_t r;
    if (!model_loaded || round >= 15) begin
      r.err = 1'b1;
      r.key = '0;
    end else begin
      r.err = 1'b0;
      r.key = model_key[mode ? 14 - round : round];
    end
    return r;
  endfunction

  // Scoreboard: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected got rd_valid=1 want no response");
      end else begin
        resp_t e;
        e = q.pop_front();
        if (rd_err !== e.err || rd_key !== e.key) begin
          n_err++;
          $display("FAIL rd_resp got err=%b key=%h want err=%b key=%h",
                   rd_err, rd_key, e.err, e.key);
        end
      end
    end
  end

  task automatic issue_rd(input logic mode, input int round);
    rd_req   = 1'b1;
    rd_mode  = mode;
    rd_round = 4'(round);
    q.push_back(exp_of(mode, round));
  endtask

  task automatic read1(input logic mode, input int round);
    issue_rd(mode, round);
    @(posedge clk); #1;
    rd_req = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL rd_missing round=%0d got pending=%0d want 0", round, q.size());
      q.delete();
    end
  endtask

  task automatic build_model(input logic [31:0] base);
    for (int k = 0; k < 15; k++)
      model_key[k] = {base + 32'(4*k), base + 32'(4*k+1), base + 32'(4*k+2), base + 32'(4*k+3)};
  endtask

  task automatic load_all(input logic [31:0] base, input bit gaps, input bit rd_on_last);
    n_vec++;
    if (ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_ready got %b want 1", ld_ready);
    end
    for (int i = 0; i < 60; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      ld_valid = 1'b1;
      ld_data  = base + 32'(i);
      if (i == 59) begin
        n_vec++;
        if (keys_loaded !== 1'b0) begin
          n_err++;
          $display("FAIL loaded_early got %b want 0", keys_loaded);
        end
        if (rd_on_last) issue_rd(1'b0, 0);
      end
      @(posedge clk); #1;
      rd_req = 1'b0;
    end
    ld_valid = 1'b0;
    build_model(base);
    model_loaded = 1;
    n_vec++;
    if (keys_loaded !== 1'b1 || ld_ready !== 1'b0) begin
      n_err++;
      $display("FAIL load_done got loaded=%b ready=%b want loaded=1 ready=0",
               keys_loaded, ld_ready);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (ld_ready !== 1'b1 || keys_loaded !== 1'b0 || rd_valid !== 1'b0 ||
        rd_key !== '0 || rd_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vals got rdy=%b ld=%b v=%b k=%h e=%b want 1 0 0 0 0",
               ld_ready, keys_loaded, rd_valid, rd_key, rd_err);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    read1(1'b0, 0);
    n_vec++;
    if (rd_err !== 1'b1 || rd_key !== '0) begin
      n_err++;
      $display("FAIL reset_read got err=%b key=%h want err=1 key=0", rd_err, rd_key);
    end
  endtask

  task automatic test_load;
    load_all(32'h1000_0000, 0, 0);
    read1(1'b0, 0);
    n_vec++;
    if (rd_key !== 128'h10000000_10000001_10000002_10000003) begin
      n_err++;
      $display("FAIL key0_literal got %h want 10000000100000011000000210000003", rd_key);
    end
    read1(1'b0, 14);
    n_vec++;
    if (rd_key !== 128'h10000038_10000039_1000003a_1000003b) begin
      n_err++;
      $display("FAIL key14_literal got %h want 100000381000003910000 03a1000003b", rd_key);
    end
    @(posedge clk); #1;
    n_vec++;
    if (rd_valid !== 1'b0 || rd_key !== 128'h10000038_10000039_1000003a_1000003b) begin
      n_err++;
      $display("FAIL idle_hold got v=%b key=%h want v=0 key held", rd_valid, rd_key);
    end
  endtask

  task automatic test_decrypt_b2b;
    read1(1'b1, 0);
    n_vec++;
    if (rd_key !== 128'h10000038_10000039_1000003a_1000003b) begin
      n_err++;
      $display("FAIL dec_round0 got %h want key 14", rd_key);
    end
    for (int r = 0; r < 3; r++) begin
      issue_rd(1'b1, r);
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (rd_valid !== 1'b0 || q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_drain got v=%b pending=%0d want v=0 pending=0", rd_valid, q.size());
      q.delete();
    end
  endtask

  task automatic test_out_of_range;
    read1(1'b0, 15);
    n_vec++;
    if (rd_err !== 1'b1 || rd_key !== '0) begin
      n_err++;
      $display("FAIL oob_enc got err=%b key=%h want err=1 key=0", rd_err, rd_key);
    end
    read1(1'b1, 15);
  endtask

  task automatic test_loaded_ignores_ld;
    ld_valid = 1'b1;
    ld_data  = 32'hdead_beef;
    repeat (5) @(posedge clk);
    #1;
    ld_valid = 1'b0;
    n_vec++;
    if (ld_ready !== 1'b0 || keys_loaded !== 1'b1) begin
      n_err++;
      $display("FAIL loaded_ign got rdy=%b ld=%b want rdy=0 ld=1", ld_ready, keys_loaded);
    end
    read1(1'b0, 0);
    read1(1'b0, 1);
  endtask

  task automatic test_clear_mid_load;
    // Read coinciding with clear sees the pre-clear, loaded store.
    issue_rd(1'b0, 3);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    rd_req = 1'b0;
    model_loaded = 0;
    n_vec++;
    if (keys_loaded !== 1'b0 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clear_state got ld=%b rdy=%b want ld=0 rdy=1", keys_loaded, ld_ready);
    end
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h5000_0000 + 32'(i);
      @(posedge clk); #1;
    end
    ld_data = 32'hbadb_ad00;
    clear   = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
    ld_valid = 1'b0;
    n_vec++;
    if (keys_loaded !== 1'b0) begin
      n_err++;
      $display("FAIL clear_mid got ld=%b want 0", keys_loaded);
    end
    read1(1'b0, 1);
    load_all(32'h5000_0000, 0, 0);
    for (int r = 0; r < 15; r++) read1(1'b0, r);
    read1(1'b0, 1);
    n_vec++;
    if (rd_key !== 128'h50000004_50000005_50000006_50000007) begin
      n_err++;
      $display("FAIL reload_key1 got %h want 50000004500000055000000650000007", rd_key);
    end
  endtask

  task automatic test_gap_load;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_loaded = 0;
    load_all(32'h1000_0000, 1, 1);
    for (int r = 0; r < 15; r++) read1(1'b0, r);
    read1(1'b1, 5);
    read1(1'b0, 0);
    n_vec++;
    if (rd_key !== 128'h10000000_10000001_10000002_10000003) begin
      n_err++;
      $display("FAIL gap_key0 got %h want 10000000100000011000000210000003", rd_key);
    end
  endtask

  task automatic test_reset_mid;
    issue_rd(1'b0, 2);
    @(posedge clk); #1;
    rd_req = 1'b0;
    #1 resetn = 1'b1;
    #1;
    n_vec++;
    if (rd_valid !== 1'b0 || rd_key !== '0 || ld_ready !== 1'b1 || keys_loaded !== 1'b0) begin
      n_err++;
      $display("FAIL reset_read_flight got v=%b key=%h rdy=%b ld=%b want 0 0 1 0",
               rd_valid, rd_key, ld_ready, keys_loaded);
    end
    q.delete();
    model_loaded = 0;
    @(posedge clk); #1;
    resetn = 1'b0;
    read1(1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h6000_0000 + 32'(i);
      @(posedge clk); #1;
    end
    #2 resetn = 1'b1;
    #1;
    n_vec++;
    if (ld_ready !== 1'b1 || keys_loaded !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_load got rdy=%b ld=%b want rdy=1 ld=0", ld_ready, keys_loaded);
    end
    ld_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    read1(1'b0, 0);
    load_all(32'h7000_0000, 0, 0);
    read1(1'b0, 0);
    n_vec++;
    if (rd_key !== 128'h70000000_70000001_70000002_70000003) begin
      n_err++;
      $display("FAIL post_reset_key0 got %h want 70000000700000017000000270000003", rd_key);
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_decrypt_b2b;
    test_out_of_range;
    test_loaded_ignores_ld;
    test_clear_mid_load;
    test_gap_load;
    test_reset_mid;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/round_key_store.md
Name: round_key_store

Overview:
Round-key storage for the AES256 datapath. Replaces the fixed, file-initialised key ROM with a run-time loadable store. Keys are loaded as a 32-bit word stream through a valid/ready handshake. Reads are registered, with enc/dec address mapping selected per request, and an error flag covers unloaded or out-of-range rounds. The block sits between the key source (host or key expansion) and the addRK stage.

Parameters:
DATA_WIDTH, 128, round-key width in bits
WORD_WIDTH, 32, load word width; DATA_WIDTH must be a multiple of it
NUM_KEYS, 15, number of round keys (AES256 = 15)
ADDR_WIDTH, 4, round index width; 2**ADDR_WIDTH >= NUM_KEYS

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  asynchronous reset, active-high (asserted = 1)
clear  in  1  sync pulse: invalidate store, restart load at key 0 word 0
ld_valid  in  1  load word valid
ld_data  in  WORD_WIDTH  load word
ld_ready  out  1  store accepts a word (high only in LOAD state)
keys_loaded  out  1  all NUM_KEYS keys written
rd_req  in  1  read request, one per cycle allowed
rd_mode  in  1  0 = encrypt (physical = round), 1 = decrypt (physical = NUM_KEYS-1-round)
rd_round  in  ADDR_WIDTH  logical round index
rd_valid  out  1  read response strobe, one cycle
rd_key  out  DATA_WIDTH  round key; 0 when rd_err
rd_err  out  1  response invalid: not loaded, or rd_round >= NUM_KEYS

Behaviour:
- Reset values: ld_ready=1, keys_loaded=0, rd_valid=0, rd_key=0, rd_err=0. Word and key counters are 0, FSM is LOAD. Storage array is not reset.
- FSM states:
  - LOAD: ld_ready=1. A word transfers when ld_valid && ld_ready.
  - LOADED: ld_ready=0, keys_loaded=1.
- Word packing: WPK = DATA_WIDTH/WORD_WIDTH. Word 0 of a key fills the MSBs ([127:96]), word WPK-1 fills the LSBs.
- Key commit: after word WPK-1 of key k, the assembled key is written to entry k in the same edge. The word counter wraps to 0 and the key counter increments.
- The transfer of the last word of key NUM_KEYS-1 moves the FSM to LOADED. keys_loaded rises the next cycle; no intermediate state.
- In LOADED, ld_valid is ignored; no counter change, no write.
- clear (either state): counters go to 0, FSM goes to LOAD, keys_loaded goes to 0 the next cycle. A partially assembled key is discarded; storage contents are left stale.
- clear has priority over a same-cycle ld_valid; that word is dropped.
- Read latency is 1 cycle: rd_req in cycle N gives rd_valid=1 in cycle N+1 with rd_key/rd_err. With no request, rd_valid=0 and rd_key/rd_err hold their last values.
- rd_err=1 and rd_key=0 when keys_loaded=0 at request time, or when rd_round >= NUM_KEYS. The range check applies before mode mapping.
- A rd_req in the same cycle as the final load word sees keys_loaded=0, so it returns an error.
- A rd_req in the same cycle as clear is evaluated against pre-clear state: if loaded, it returns valid data.
- rd_mode is sampled with rd_req only; no mode state is held.
- Back-to-back rd_req every cycle is fully pipelined, giving one response per cycle.
- resetn asserted mid-load or mid-read: outputs go immediately to reset values and any in-flight response is lost.

Decomposition:
- Package aes_key_pkg:
  - AES256_NUM_RK=15, KEY_W=128, WORD_W=32
  - typedef rk_t (logic [KEY_W-1:0])
  - enum rk_mode_t {RK_ENC=0, RK_DEC=1}
  - enum rk_state_t {RK_LOAD, RK_LOADED}
- Sub-module rk_word_packer: shift-in word assembler with word counter; emits key_valid plus the packed key on the last word. The top level holds the FSM, the key counter, the storage array and the read pipeline.

Test Plan:
- Reset, then rd_req round 0 mode 0 -> next cycle rd_valid=1, rd_err=1, rd_key=0; ld_ready=1, keys_loaded=0.
- Load 60 words, word i = 32'h1000_0000+i, with ld_valid held -> keys_loaded=1 on the cycle after word 59 and ld_ready=0. rd round 0 mode 0 -> 128'h10000000_10000001_10000002_10000003. rd round 14 mode 0 -> words 56..59.
- After load, rd round 0 mode 1 -> key 14 (words 56..59). Back-to-back rounds 0,1,2 in mode 1 -> keys 14,13,12 on three consecutive cycles.
- rd_round=15 with keys loaded -> rd_err=1, rd_key=0. Extra ld_valid in LOADED -> no change in a subsequent readback of key 0.
- Toggle ld_valid with random gaps for the full load -> identical readback to the gap-free load.
- clear after 6 words (mid key 1) with ld_valid high that cycle -> word dropped, keys_loaded=0. Reload 60 words -> key 1 equals the new data. resetn pulsed mid-load -> ld_ready=1, keys_loaded=0, and the next read errors.
